bcd_display_scan: RTL and testbench

//   Downstream consumer of the BCD adder result digits. Holds a multi-digit BCD value and

---
 rtl/bcd_display_scan_pkg.sv | 20 ++
 rtl/bcd_display_scan_if.sv | 24 ++
 rtl/bcd_display_scan_bcd_to_seg.sv | 33 +++
 rtl/bcd_display_scan.sv | 114 +++++++++++
 tb/tb_bcd_display_scan.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bcd_display_scan_pkg.sv
// Shared BCD constants and seven-segment patterns.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Display scanner bus: load strobe and digits in,
// segment/anode drive and frame marker out.
interface bcd_display_scan_if #(
  parameter int NUM_DIGITS = 2
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output load, bcd_in, blank_lz,
    input  seg, an, frame_done
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output seg, an, frame_done
  );

endinterface

// File: rtl/bcd_display_scan_bcd_to_seg.sv
// One BCD digit to active-high segments.
// Values above 9 show 'E'; blank forces all off.
module bcd_to_seg
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             blank,
  output logic [6:0]       seg
);

  // digit decode with blanking override
  always_comb begin
    seg = SEG_E;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment scanner with
// frame-aligned (tear-free) value commits.
module bcd_display_scan
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input logic              clk,
  input logic              rst_n,
  bcd_display_scan_if.slave bus
);

  localparam int DW = BCD_W * NUM_DIGITS;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ?
                      $clog2(NUM_DIGITS) : 1;
  localparam bit INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         disp;
  logic [DW-1:0]         pending;
  logic                  pend_v;
  logic                  tc;
  logic                  wrap;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] onehot;
  logic [BCD_W-1:0]      cur;
  logic                  cur_blank;
  logic [6:0]            seg_hi;

  assign tc   = (div_cnt == CW'(REFRESH_DIV - 1));
  assign wrap = tc && (idx == IW'(NUM_DIGITS - 1));

  // refresh divider and scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tc) begin
      div_cnt <= '0;
      idx     <= wrap ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // pending capture; commit to disp only at frame wrap
  // (a load on the wrap cycle stays pending for next frame)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp    <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
    end else begin
      if (wrap && pend_v)
        disp <= pending;
      if (bus.load) begin
        pending <= bus.bcd_in;
        pend_v  <= 1'b1;
      end else if (wrap) begin
        pend_v  <= 1'b0;
      end
    end
  end

  // leading-zero mask: blank while all higher digits are zero
  always_comb begin
    blank_mask = '0;
    zero_run   = bus.blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run &&
                      (disp[i*BCD_W +: BCD_W] == '0);
      blank_mask[i] = zero_run;
    end
  end

  // select the digit under scan
  always_comb begin
    cur       = '0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur       = disp[i*BCD_W +: BCD_W];
        cur_blank = blank_mask[i];
        onehot[i] = 1'b1;
      end
    end
  end

  bcd_to_seg u_dec (
    .digit (cur),
    .blank (cur_blank),
    .seg   (seg_hi)
  );

  // registered drive; polarity applied here only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg        <= {7{INV}};
      bus.an         <= {NUM_DIGITS{INV}};
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg        <= seg_hi ^ {7{INV}};
      bus.an         <= onehot ^ {NUM_DIGITS{INV}};
      bus.frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: decode table,
// frame-ordering sequences and reset cases.
module tb_bcd_display_scan;

  typedef struct {
    logic [7:0] val;
    logic       blz;
    logic [6:0] s0;
    logic [6:0] s1;
  } vec_t;

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  exp_t q[$];
  vec_t vt[9];

  always #5 clk = ~clk;

  bcd_display_scan_if #(.NUM_DIGITS(2)) bus ();

  bcd_display_scan #(
    .NUM_DIGITS  (2),
    .REFRESH_DIV (4),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic push_frame(input logic [6:0] s0,
                            input logic [6:0] s1);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.an  = (i < 4) ? 2'b10 : 2'b01;
      e.seg = (i < 4) ? s0 : s1;
      e.fd  = (i == 7);
      q.push_back(e);
    end
  endtask

  task automatic check_frame(input string nm);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        total++;
        $display("FAIL %s: scoreboard empty", nm);
      end else begin
        e = q.pop_front();
        chk($sformatf("%s.an[%0d]", nm, i),
            {6'b0, bus.an}, {6'b0, e.an});
        chk($sformatf("%s.seg[%0d]", nm, i),
            {1'b0, bus.seg}, {1'b0, e.seg});
        chk($sformatf("%s.fd[%0d]", nm, i),
            {7'b0, bus.frame_done}, {7'b0, e.fd});
      end
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 20);
    if (!bus.frame_done) begin
      total++;
      $display("FAIL fd_timeout: got none in %0d", n);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.bcd_in = v;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  initial begin
    int n;
    vt[0] = '{8'h17, 1'b0, 7'h78, 7'h79};
    vt[1] = '{8'h05, 1'b1, 7'h12, 7'h7F};
    vt[2] = '{8'h00, 1'b1, 7'h40, 7'h7F};
    vt[3] = '{8'hA3, 1'b0, 7'h30, 7'h06};
    vt[4] = '{8'h05, 1'b0, 7'h12, 7'h40};
    vt[5] = '{8'h90, 1'b1, 7'h40, 7'h10};
    vt[6] = '{8'h4B, 1'b1, 7'h06, 7'h19};
    vt[7] = '{8'h00, 1'b0, 7'h40, 7'h40};
    vt[8] = '{8'h86, 1'b0, 7'h02, 7'h00};

    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.bcd_in   = '0;
    bus.blank_lz = 1'b0;

    #12;
    chk("rst.seg", {1'b0, bus.seg}, 8'h7F);
    chk("rst.an", {6'b0, bus.an}, 8'h03);
    chk("rst.fd", {7'b0, bus.frame_done}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.an", {6'b0, bus.an}, 8'h02);
    chk("rel.seg", {1'b0, bus.seg}, 8'h40);

    wait_fd(n);
    chk("first_fd", n[7:0], 8'd8);
    wait_fd(n);
    chk("fd_period", n[7:0], 8'd8);

    for (int k = 0; k < 9; k++) begin
      bus.blank_lz = vt[k].blz;
      do_load(vt[k].val);
      push_frame(vt[k].s0, vt[k].s1);
      wait_fd(n);
      check_frame($sformatf("vec%0d", k));
    end

    bus.blank_lz = 1'b0;
    do_load(8'h11);
    @(negedge clk);
    do_load(8'h22);
    repeat (4) @(negedge clk);
    bus.bcd_in = 8'h33;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    chk("wrap_load.fd", {7'b0, bus.frame_done}, 8'h01);
    push_frame(7'h24, 7'h24);
    check_frame("upd22");
    push_frame(7'h30, 7'h30);
    check_frame("upd33");

    do_load(8'h44);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.seg", {1'b0, bus.seg}, 8'h7F);
    chk("mid_rst.an", {6'b0, bus.an}, 8'h03);
    chk("mid_rst.fd", {7'b0, bus.frame_done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel.an", {6'b0, bus.an}, 8'h02);
    chk("mid_rel.seg", {1'b0, bus.seg}, 8'h40);
    wait_fd(n);
    chk("mid_rel.fd", n[7:0], 8'd8);
    push_frame(7'h40, 7'h40);
    check_frame("post_rst");
    push_frame(7'h40, 7'h40);
    check_frame("post_rst2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
